// File: rtl/time_redundancy_pkg.sv
// Shared definitions for the time-redundancy start/end block pair.
// ID parity encoding and replica-index sizing live here so both ends agree.
package time_redundancy_pkg;

    localparam int unsigned MaxIdSize = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } nmr_state_e;

    // Width of the replica index: max(1, clog2(replicas)).
    function automatic int unsigned rep_idx_width(input int unsigned replicas);
        return (replicas <= 1) ? 1 : $clog2(replicas);
    endfunction

    // Returns {^cnt, cnt} right-aligned in an id_size-bit field.
    function automatic logic [MaxIdSize-1:0] id_with_parity(input logic [MaxIdSize-1:0] cnt,
                                                             input int unsigned      id_size);
        logic [MaxIdSize-1:0] mask;
        logic [MaxIdSize-1:0] low;
        mask = (MaxIdSize'(1) << (id_size - 1)) - MaxIdSize'(1);
        low  = cnt & mask;
        return low | (MaxIdSize'(^low) << (id_size - 1));
    endfunction

endpackage

// File: rtl/time_nmr_id_gen.sv
// Item ID source: parity-protected wrapping counter or external ID,
// registered on every upstream accept.
module time_nmr_id_gen
    import time_redundancy_pkg::*;
#(
    parameter int unsigned IDSize        = 2,
    parameter bit          UseExternalId = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              accept_i,
    input  logic [IDSize-1:0] id_i,
    output logic [IDSize-1:0] id_o,
    output logic [IDSize-1:0] next_id_o
);

    localparam int unsigned CntW = (IDSize > 1) ? IDSize - 1 : 1;

    logic [IDSize-1:0] r_id_q;
    logic [CntW-1:0]   w_cnt;
    logic [IDSize-1:0] w_int_id;

    // Counter field wraps naturally at 2^(IDSize-1); MSB carries its parity.
    assign w_cnt     = r_id_q[CntW-1:0] + CntW'(1);
    assign w_int_id  = IDSize'(id_with_parity(MaxIdSize'(w_cnt), IDSize));
    assign next_id_o = UseExternalId ? id_i : w_int_id;
    assign id_o      = r_id_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id_q <= '0;
        end else if (accept_i) begin
            r_id_q <= next_id_o;
        end
    end

endmodule

// File: rtl/time_nmr_start.sv
// Time-redundancy issue stage: re-issues each accepted item Replicas times
// (or once when redundancy is disabled), tagging copies with ID and index.
module time_nmr_start
    import time_redundancy_pkg::*;
#(
    parameter type         DataType      = logic,
    parameter int unsigned Replicas      = 2,
    parameter int unsigned IDSize        = 2,
    parameter bit          UseExternalId = 1'b0,
    localparam int unsigned RepIdxWidth  = rep_idx_width(Replicas)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   flush_i,
    output logic [IDSize-1:0]      next_id_o,
    input  DataType                data_i,
    input  logic [IDSize-1:0]      id_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output DataType                data_o,
    output logic [IDSize-1:0]      id_o,
    output logic [RepIdxWidth-1:0] rep_idx_o,
    output logic                   last_o,
    output logic                   valid_o,
    input  logic                   ready_i
);

    localparam logic [RepIdxWidth-1:0] LastRep = RepIdxWidth'(Replicas - 1);

    nmr_state_e             r_state;
    DataType                r_data;
    logic [RepIdxWidth-1:0] r_rep;
    logic                   r_mode;
    logic [IDSize-1:0]      w_id_q;
    logic                   w_accept;
    logic                   w_last_issue;

    assign w_accept     = (r_state == ST_IDLE) && valid_i;
    assign w_last_issue = (r_rep == LastRep) || !r_mode;

    time_nmr_id_gen #(
        .IDSize        (IDSize),
        .UseExternalId (UseExternalId)
    ) u_id_gen (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .accept_i  (w_accept),
        .id_i      (id_i),
        .id_o      (w_id_q),
        .next_id_o (next_id_o)
    );

    // Copy 0 passes straight through in IDLE; later copies come from the held item.
    always_comb begin
        ready_o   = 1'b1;
        valid_o   = valid_i;
        data_o    = data_i;
        id_o      = next_id_o;
        rep_idx_o = '0;
        last_o    = ~enable_i;
        if (r_state == ST_ISSUE) begin
            ready_o   = 1'b0;
            valid_o   = 1'b1;
            data_o    = r_data;
            id_o      = w_id_q;
            rep_idx_o = r_rep;
            last_o    = w_last_issue;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_rep   <= '0;
            r_mode  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= data_i;
                r_mode <= enable_i;
            end
            // Flush wins over any sequencing decision this cycle.
            if (flush_i) begin
                r_state <= ST_IDLE;
                r_rep   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (valid_i) begin
                            if (!ready_i) begin
                                r_rep   <= '0;
                                r_state <= ST_ISSUE;
                            end else if (enable_i) begin
                                r_rep   <= RepIdxWidth'(1);
                                r_state <= ST_ISSUE;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (ready_i) begin
                            if (w_last_issue) begin
                                r_state <= ST_IDLE;
                                r_rep   <= '0;
                            end else begin
                                r_rep <= r_rep + RepIdxWidth'(1);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_time_nmr_start.sv
// Randomized scoreboard bench for time_nmr_start (TMR, internal IDs) plus a
// short directed check of an external-ID DMR instance.
module tb_time_nmr_start;

    localparam int unsigned REP = 3;
    localparam int unsigned IDW = 3;

    typedef struct packed {
        logic [7:0]     d;
        logic [IDW-1:0] id;
        logic [1:0]     rep;
        logic           last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           enable_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
    logic [7:0]     data_i = '0;
    logic [IDW-1:0] id_i = '0;
    logic [IDW-1:0] next_id_o, id_o;
    logic           ready_o, last_o, valid_o;
    logic [7:0]     data_o;
    logic [1:0]     rep_idx_o;

    time_nmr_start #(
        .DataType (logic [7:0]), .Replicas (REP), .IDSize (IDW), .UseExternalId (1'b0)
    ) u_dut (
        .clk_i (clk), .rst_ni (rst_n), .enable_i (enable_i), .flush_i (flush_i),
        .next_id_o (next_id_o), .data_i (data_i), .id_i (id_i), .valid_i (valid_i),
        .ready_o (ready_o), .data_o (data_o), .id_o (id_o), .rep_idx_o (rep_idx_o),
        .last_o (last_o), .valid_o (valid_o), .ready_i (ready_i)
    );

    logic           e_en = 1'b0, e_flush = 1'b0, e_valid = 1'b0, e_ready = 1'b1;
    logic [7:0]     e_data = '0;
    logic [IDW-1:0] e_id_i = '0;
    logic [IDW-1:0] e_next_id, e_id_o;
    logic           e_ready_o, e_last, e_valid_o;
    logic [7:0]     e_data_o;
    logic [0:0]     e_rep;

    time_nmr_start #(
        .DataType (logic [7:0]), .Replicas (2), .IDSize (IDW), .UseExternalId (1'b1)
    ) u_ext (
        .clk_i (clk), .rst_ni (rst_n), .enable_i (e_en), .flush_i (e_flush),
        .next_id_o (e_next_id), .data_i (e_data), .id_i (e_id_i), .valid_i (e_valid),
        .ready_o (e_ready_o), .data_o (e_data_o), .id_o (e_id_o), .rep_idx_o (e_rep),
        .last_o (e_last), .valid_o (e_valid_o), .ready_i (e_ready)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t pend[$];
    beat_t sb[$];
    int    m_items = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ID of the (items+1)-th item since reset: counter field plus its parity on top.
    function automatic logic [IDW-1:0] model_id(input int items);
        int c;
        c = (items + 1) % (1 << (IDW - 1));
        return IDW'((($countones(c) % 2) << (IDW - 1)) + c);
    endfunction

    // Model of the cycle ending at the coming posedge; inputs are already applied.
    task automatic model_step();
        logic idle;
        int   n;
        beat_t b;
        idle = (pend.size() == 0);
        chk("ready_o", 32'(ready_o), 32'(idle));
        chk("valid_o", 32'(valid_o), idle ? 32'(valid_i) : 32'(1));
        chk("next_id", 32'(next_id_o), 32'(model_id(m_items)));
        if (idle && valid_i) begin
            n = enable_i ? REP : 1;
            for (int r = 0; r < n; r++) begin
                b.d = data_i; b.id = model_id(m_items); b.rep = 2'(r); b.last = (r == n - 1);
                pend.push_back(b);
            end
            m_items++;
        end
        if (pend.size() > 0 && !ready_i)
            chk("hold", 32'({data_o, id_o, rep_idx_o, last_o}), 32'(pend[0]));
        if (ready_i && pend.size() > 0) sb.push_back(pend.pop_front());
        if (flush_i) pend.delete();
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic en,
                        input logic rdy, input logic fl);
        @(negedge clk);
        valid_i = v; data_i = d; enable_i = en; ready_i = rdy; flush_i = fl;
        #1;
        model_step();
    endtask

    // Monitor: every downstream handshake must match the oldest expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL beat: unexpected beat 0x%0h expected none at %0t",
                             {data_o, id_o, rep_idx_o, last_o}, $time);
                end else begin
                    e = sb.pop_front();
                    chk("beat", 32'({data_o, id_o, rep_idx_o, last_o}), 32'(e));
                end
            end
        end
    end

    initial begin
        valid_i = 1'b1;
        #3;
        chk("rst_ready", 32'(ready_o), 32'(1));
        chk("rst_valid", 32'(valid_o), 32'(1));
        chk("rst_rep", 32'(rep_idx_o), 32'(0));
        valid_i = 1'b0;
        #1;
        chk("rst_valid0", 32'(valid_o), 32'(0));
        @(negedge clk); rst_n = 1'b1;

        step(1, 8'hA5, 1, 1, 0); step(0, 8'h00, 1, 1, 0); step(0, 8'h00, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 1, 0);
        step(1, 8'h5A, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1, 0);
        step(1, 8'h77, 1, 1, 0); step(0, 8'h00, 0, 1, 0); step(0, 8'h00, 0, 1, 0);
        step(1, 8'h88, 0, 1, 0);
        step(1, 8'h99, 1, 1, 0); step(0, 8'h00, 1, 1, 1);
        step(1, 8'hBB, 1, 1, 0); step(0, 8'h00, 1, 1, 0); step(0, 8'h00, 1, 1, 0);

        for (int i = 0; i < 3000; i++)
            step(($urandom % 10) < 7, 8'($urandom), ($urandom % 10) < 6,
                 ($urandom % 10) < 7, ($urandom % 20) == 0);

        // Reset in the middle of a sequence discards the remaining copies.
        step(1, 8'hC3, 1, 1, 0);
        @(negedge clk);
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
        pend.delete(); m_items = 0;
        #1;
        chk("midrst_ready", 32'(ready_o), 32'(1));
        @(negedge clk); rst_n = 1'b1;
        step(1, 8'hD4, 1, 1, 0); step(0, 8'h00, 1, 1, 0); step(0, 8'h00, 1, 1, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        valid_i = 1'b0; ready_i = 1'b0;

        @(negedge clk); e_id_i = 3'b110; #1;
        chk("ext_next_id", 32'(e_next_id), 32'(3'b110));
        @(negedge clk); e_valid = 1'b1; e_en = 1'b1; e_ready = 1'b1; e_data = 8'h3C; #1;
        chk("ext_beat0", 32'({e_valid_o, e_data_o, e_id_o, e_rep, e_last}),
            32'({1'b1, 8'h3C, 3'b110, 1'b0, 1'b0}));
        @(negedge clk); e_valid = 1'b0; e_id_i = 3'b011; #1;
        chk("ext_beat1", 32'({e_valid_o, e_data_o, e_id_o, e_rep, e_last}),
            32'({1'b1, 8'h3C, 3'b110, 1'b1, 1'b1}));
        chk("ext_busy", 32'(e_ready_o), 32'(0));
        chk("ext_next_id2", 32'(e_next_id), 32'(3'b011));
        @(negedge clk); #1;
        chk("ext_idle", 32'(e_ready_o), 32'(1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/time_nmr_start.md
Name: time_nmr_start

Overview:
- Parametrised successor to the DMR-only time-redundancy issue stage.
- Accepts one item per upstream handshake and re-issues it downstream Replicas times (2 = DMR, 3 = TMR, up to 7), all copies tagged with the same ID.
- Adds per-copy replica index, last-copy flag, per-item mode latching and synchronous flush.
- Sits in front of a time-redundant pipeline; the matching end block votes on copies with equal ID.

Parameters:
- DataType, logic: payload type carried and replicated.
- Replicas, 2: copies per item when redundancy is enabled; legal 2..7.
- IDSize, 2: ID width; MSB is parity of the lower bits; must be >= 2 when UseExternalId=0; must match the end block.
- UseExternalId, 0: 1 = use id_i as the item ID instead of the internal counter.
- RepIdxWidth, derived: max(1, $clog2(Replicas)); localparam, not user-settable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  1 = replicate Replicas times; 0 = single copy (pass-through)
- flush_i  in  1  synchronous abort of the in-flight sequence
- next_id_o  out  IDSize  ID the next accepted item will receive
- data_i  in  DataType  upstream payload
- id_i  in  IDSize  external ID, used only when UseExternalId=1
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_o  out  DataType  downstream payload
- id_o  out  IDSize  downstream ID
- rep_idx_o  out  RepIdxWidth  copy number of the current beat, 0..Replicas-1
- last_o  out  1  current beat is the final copy of its item
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready

Behaviour:
- State machine has two states: IDLE and ISSUE.
- Registers: state_q, data_q, id_q, rep_q, mode_q (enable latched at accept).
- IDLE:
  - ready_o=1 and valid_o=valid_i.
  - data_o=data_i, id_o=next_id_o, rep_idx_o=0.
  - last_o=~enable_i.
  - Copy 0 is combinational: zero latency.
- Accept happens when valid_i in IDLE. On accept: latch data, ID and enable into mode_q.
  - ready_i=1 and enable_i=1: rep_q<=1, go to ISSUE.
  - ready_i=1 and enable_i=0: stay in IDLE.
  - ready_i=0: rep_q<=0, go to ISSUE, holding copy 0.
- ISSUE:
  - ready_o=0 and valid_o=1.
  - data_o=data_q, id_o=id_q, rep_idx_o=rep_q.
  - last_o=(rep_q==Replicas-1) or (mode_q==0).
  - On ready_i: if last_o, go to IDLE; else rep_q<=rep_q+1.
- enable_i is sampled only at accept. Changes mid-sequence have no effect on the current item.
- data_o, id_o, rep_idx_o and last_o are stable while valid_o=1 and ready_i=0.
- Internal ID:
  - next_id_o = {^cnt, cnt}, where cnt = id_q[IDSize-2:0]+1 (modulo 2^(IDSize-1)).
  - Wraps all-ones -> 0, which gives an ID of all zeros.
  - id_q updates only on accept.
- External ID: next_id_o=id_i, latched at accept.
- flush_i:
  - Overrides the next state: state<=IDLE, rep_q<=0.
  - id_q and data_q are kept.
  - The current-cycle outputs are still driven.
  - If a downstream handshake completes in the same cycle, it counts. If an accept coincides, the item is dropped but id_q still advances.
- Reset, asynchronous: state IDLE, data_q=0, id_q=0, rep_q=0, mode_q=0.
  - Outputs during reset follow IDLE: ready_o=1, valid_o=valid_i, rep_idx_o=0.
  - Reset mid-sequence discards the remaining copies.
- Throughput: one item per Replicas cycles when enabled and ready_i is held high; one per cycle when disabled.

Decomposition:
- Shared package time_redundancy_pkg:
  - function id_with_parity(cnt) returning {^cnt, cnt}.
  - rep_idx width helper function.
  - The same definitions are reused by the matching end block.
- Sub-module time_nmr_id_gen: holds the counter and parity, produces next_id_o, and contains the internal/external ID mux.
- The FSM stays in the top module.

Test Plan:
- Replicas=3, IDSize=3, enable=1, ready_i=1, one item 0xA5 -> three beats 0xA5, id=3'b101, rep_idx 0,1,2, last only on beat 2. ready_o low for 2 cycles.
- enable=0, 4 back-to-back items -> one beat each. IDs 101, 110, 011, 000 (wrap). last_o=1 every beat. ready_o constant 1.
- Replicas=2, ready_i=0 at accept, held low 3 cycles -> copy 0 held stable with rep_idx=0. Then 2 beats are issued after ready_i rises.
- enable toggled 1->0 during rep_idx=1 of a TMR item -> all 3 copies still issued. The next item is single-copy.
- flush_i asserted at rep_idx=1 -> next cycle IDLE, ready_o=1. The next accepted item gets the following ID (no reuse).
- UseExternalId=1, id_i=3'b110 -> all copies carry 110. next_id_o tracks id_i.
